// File: rtl/gate_response_checker_pkg.sv
// Shared types, mask bit positions and the reference truth table for the
// two-input gate response checker.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int MSK_AND   = 0;
   localparam int MSK_OR    = 1;
   localparam int MSK_NOT_A = 2;
   localparam int MSK_XOR   = 3;
   localparam int MSK_XNOR  = 4;
   localparam int MSK_NAND  = 5;
   localparam int MSK_W     = 6;

   function automatic logic [MSK_W-1:0] gate_expected(input logic a, input logic b);
      logic [MSK_W-1:0] e;
      e            = '0;
      e[MSK_AND]   = a & b;
      e[MSK_OR]    = a | b;
      e[MSK_NOT_A] = ~a;
      e[MSK_XOR]   = a ^ b;
      e[MSK_XNOR]  = ~(a ^ b);
      e[MSK_NAND]  = ~(a & b);
      return e;
   endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Bundle of the sampled gate-block signals and the checker's result outputs.
interface gate_response_checker_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             sample_valid;
   logic             a;
   logic             b;
   logic             and_g;
   logic             or_g;
   logic             not_a_g;
   logic             xor_g;
   logic             xnor_g;
   logic             nand_g;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [3:0]       coverage;
   logic [CNT_W-1:0] first_err_idx;
   logic [5:0]       first_err_mask;

   modport master (
      output start, sample_valid, a, b, and_g, or_g, not_a_g, xor_g, xnor_g, nand_g,
      input  busy, done, pass, vec_cnt, err_cnt, coverage, first_err_idx, first_err_mask
   );

   modport slave (
      input  start, sample_valid, a, b, and_g, or_g, not_a_g, xor_g, xnor_g, nand_g,
      output busy, done, pass, vec_cnt, err_cnt, coverage, first_err_idx, first_err_mask
   );

endinterface

// File: rtl/gate_response_checker_ref_model.sv
// Combinational expected-output generator for the two-input gate block.
module gate_ref_model
   import gate_chk_pkg::*;
(
   input  logic             a_i,
   input  logic             b_i,
   output logic [MSK_W-1:0] exp_o
);

   assign exp_o = gate_expected(a_i, b_i);

endmodule

// File: rtl/gate_response_checker.sv
// Response-side monitor: captures strobed gate vectors, scores them one cycle
// later against the truth table, and keeps counts, coverage and a verdict.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int NUM_VECTORS = 4,
   parameter int REQ_COVER   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   gate_response_checker_if.slave bus
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic               cap_vld_q, cap_vld_d;
   logic [1:0]         cap_ab_q, cap_ab_d;
   logic [MSK_W-1:0]   cap_obs_q, cap_obs_d;
   logic [CNT_W-1:0]   vec_q, vec_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [3:0]         cov_q, cov_d;
   logic [CNT_W-1:0]   fidx_q, fidx_d;
   logic [MSK_W-1:0]   fmask_q, fmask_d;
   logic               pass_q, pass_d;
   logic [MSK_W-1:0]   obs;
   logic [MSK_W-1:0]   exp_vec;
   logic [MSK_W-1:0]   mask;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_comb begin
      obs            = '0;
      obs[MSK_AND]   = bus.and_g;
      obs[MSK_OR]    = bus.or_g;
      obs[MSK_NOT_A] = bus.not_a_g;
      obs[MSK_XOR]   = bus.xor_g;
      obs[MSK_XNOR]  = bus.xnor_g;
      obs[MSK_NAND]  = bus.nand_g;
   end

   // Scoring works on the captured vector, never on the live inputs.
   gate_ref_model u_ref (
      .a_i   (cap_ab_q[1]),
      .b_i   (cap_ab_q[0]),
      .exp_o (exp_vec)
   );

   assign mask = exp_vec ^ cap_obs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         cap_vld_q <= 1'b0;
         cap_ab_q  <= '0;
         cap_obs_q <= '0;
         vec_q     <= '0;
         err_q     <= '0;
         cov_q     <= '0;
         fidx_q    <= '0;
         fmask_q   <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cap_vld_q <= cap_vld_d;
         cap_ab_q  <= cap_ab_d;
         cap_obs_q <= cap_obs_d;
         vec_q     <= vec_d;
         err_q     <= err_d;
         cov_q     <= cov_d;
         fidx_q    <= fidx_d;
         fmask_q   <= fmask_d;
         pass_q    <= pass_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cap_vld_d = 1'b0;
      cap_ab_d  = cap_ab_q;
      cap_obs_d = cap_obs_q;
      vec_d     = vec_q;
      err_d     = err_q;
      cov_d     = cov_q;
      fidx_d    = fidx_q;
      fmask_d   = fmask_q;
      pass_d    = pass_q;

      if (cap_vld_q) begin
         vec_d           = vec_q + 1'b1;
         cov_d[cap_ab_q] = 1'b1;
         if (mask != '0) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) begin
               fidx_d  = vec_q;
               fmask_d = mask;
            end
         end
      end

      case (state_q)
         ST_RUN: begin
            if (bus.sample_valid) begin
               cap_vld_d = 1'b1;
               cap_ab_d  = {bus.a, bus.b};
               cap_obs_d = obs;
               acc_d     = acc_q + 1'b1;
               if (acc_q == CNT_W'(NUM_VECTORS - 1)) state_d = ST_DRAIN;
            end
         end
         // Verdict uses the counters as they will stand after the final score.
         ST_DRAIN: begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0) && ((REQ_COVER == 0) || (cov_d == 4'hF));
         end
         default: ;
      endcase

      if (bus.start) begin
         state_d   = ST_RUN;
         acc_d     = '0;
         cap_vld_d = 1'b0;
         vec_d     = '0;
         err_d     = '0;
         cov_d     = '0;
         fidx_d    = '0;
         fmask_d   = '0;
         pass_d    = 1'b0;
      end
   end

   assign bus.busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.done           = (state_q == ST_DONE);
   assign bus.pass           = pass_q;
   assign bus.vec_cnt        = vec_q;
   assign bus.err_cnt        = err_q;
   assign bus.coverage       = cov_q;
   assign bus.first_err_idx  = fidx_q;
   assign bus.first_err_mask = fmask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker with a queue of expected session results.
module tb_gate_response_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_v = 1'b0;
   logic       sv_v = 1'b0;
   logic       a_v = 1'b0;
   logic       b_v = 1'b0;
   logic [5:0] g_v = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] vec;
      logic [7:0] err;
      logic [3:0] cov;
      logic [7:0] fidx;
      logic [5:0] fmask;
      logic       pass;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   gate_response_checker_if #(.CNT_W(8)) bus1 ();
   gate_response_checker_if #(.CNT_W(8)) bus0 ();

   assign bus1.start = start_v;     assign bus0.start = start_v;
   assign bus1.sample_valid = sv_v; assign bus0.sample_valid = sv_v;
   assign bus1.a = a_v;             assign bus0.a = a_v;
   assign bus1.b = b_v;             assign bus0.b = b_v;
   assign bus1.and_g = g_v[0];      assign bus0.and_g = g_v[0];
   assign bus1.or_g = g_v[1];       assign bus0.or_g = g_v[1];
   assign bus1.not_a_g = g_v[2];    assign bus0.not_a_g = g_v[2];
   assign bus1.xor_g = g_v[3];      assign bus0.xor_g = g_v[3];
   assign bus1.xnor_g = g_v[4];     assign bus0.xnor_g = g_v[4];
   assign bus1.nand_g = g_v[5];     assign bus0.nand_g = g_v[5];

   gate_response_checker #(.CNT_W(8), .NUM_VECTORS(4), .REQ_COVER(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   gate_response_checker #(.CNT_W(8), .NUM_VECTORS(4), .REQ_COVER(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Correct gate outputs, order {nand,xnor,xor,not_a,or,and}.
   function automatic logic [5:0] good_out(input logic a, input logic b);
      return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_vec(input logic [1:0] ab, input logic [5:0] flip);
      a_v = ab[1];
      b_v = ab[0];
      g_v = good_out(ab[1], ab[0]) ^ flip;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  bus1.busy, 0);
      check({tag, "_done"},  bus1.done, 0);
      check({tag, "_pass"},  bus1.pass, 0);
      check({tag, "_vec"},   bus1.vec_cnt, 0);
      check({tag, "_err"},   bus1.err_cnt, 0);
      check({tag, "_cov"},   bus1.coverage, 0);
      check({tag, "_fidx"},  bus1.first_err_idx, 0);
      check({tag, "_fmask"}, bus1.first_err_mask, 0);
   endtask

   task automatic begin_session();
      start_v = 1'b1;
      sv_v    = 1'b0;
      step();
      start_v = 1'b0;
      check("start_busy", bus1.busy, 1);
      check("start_done", bus1.done, 0);
      check("start_vec",  bus1.vec_cnt, 0);
      check("start_err",  bus1.err_cnt, 0);
   endtask

   // Vector i uses abs[2i+:2] and flips[6i+:6]; DUT is already in RUN.
   task automatic run_vectors(input logic [7:0] abs, input logic [23:0] flips,
                              input exp_t e, input logic pass0);
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         set_vec(abs[2*i +: 2], flips[6*i +: 6]);
         sv_v = 1'b1;
         step();
         check($sformatf("lat_vec%0d", i), bus1.vec_cnt, i);
      end
      sv_v = 1'b0;
      check("drain_done", bus1.done, 0);
      check("drain_busy", bus1.busy, 1);
      step();
      check("end_done", bus1.done, 1);
      check("end_busy", bus1.busy, 0);
      check("end_pass_nocov", bus0.pass, pass0);
   endtask

   // Monitor: compares a whole session result whenever done rises.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            done_prev = 1'b0;
         end else begin
            if (bus1.done && !done_prev) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_vec",   bus1.vec_cnt, e.vec);
                  check("sb_err",   bus1.err_cnt, e.err);
                  check("sb_cov",   bus1.coverage, e.cov);
                  check("sb_fidx",  bus1.first_err_idx, e.fidx);
                  check("sb_fmask", bus1.first_err_mask, e.fmask);
                  check("sb_pass",  bus1.pass, e.pass);
               end
            end
            done_prev = bus1.done;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t good_e, f1_e, f2_e, cov_e;
      good_e = '{vec: 8'd4, err: 8'd0, cov: 4'hF, fidx: 8'd0, fmask: 6'b000000, pass: 1'b1};
      f1_e   = '{vec: 8'd4, err: 8'd1, cov: 4'hF, fidx: 8'd2, fmask: 6'b001000, pass: 1'b0};
      f2_e   = '{vec: 8'd4, err: 8'd2, cov: 4'hF, fidx: 8'd0, fmask: 6'b100001, pass: 1'b0};
      cov_e  = '{vec: 8'd4, err: 8'd0, cov: 4'b0001, fidx: 8'd0, fmask: 6'b000000, pass: 1'b0};

      // Reset held for three cycles, then samples without start.
      rst_n = 1'b0;
      repeat (3) step();
      check_all_zero("rst");
      rst_n = 1'b1;
      set_vec(2'b10, 6'b001000);
      sv_v = 1'b1;
      step();
      step();
      sv_v = 1'b0;
      step();
      check("nostart_vec",  bus1.vec_cnt, 0);
      check("nostart_busy", bus1.busy, 0);

      // Exhaustive good vectors 00,01,10,11.
      begin_session();
      run_vectors(8'b11_10_01_00, 24'h000000, good_e, 1'b1);

      // xor inverted at {a,b}=10 (vector 2).
      begin_session();
      run_vectors(8'b11_10_01_00, 24'h008000, f1_e, 1'b0);

      // Two failing vectors: only the first is recorded.
      begin_session();
      run_vectors(8'b11_10_01_00, 24'h080021, f2_e, 1'b0);

      // Coverage gap: four correct 00 vectors.
      begin_session();
      run_vectors(8'b00_00_00_00, 24'h000000, cov_e, 1'b1);

      // Restart collision after two accepts, with a faulty colliding sample.
      begin_session();
      for (int i = 0; i < 2; i++) begin
         set_vec(2'b11, 6'b000000);
         sv_v = 1'b1;
         step();
      end
      start_v = 1'b1;
      set_vec(2'b01, 6'b111111);
      step();
      start_v = 1'b0;
      sv_v    = 1'b0;
      check("coll_vec",  bus1.vec_cnt, 0);
      check("coll_busy", bus1.busy, 1);
      step();
      check("coll_vec2", bus1.vec_cnt, 0);
      check("coll_err2", bus1.err_cnt, 0);
      run_vectors(8'b11_10_01_00, 24'h000000, good_e, 1'b1);

      // Reset mid-session after three accepts.
      begin_session();
      for (int i = 0; i < 3; i++) begin
         set_vec(2'(i), 6'b000100);
         sv_v = 1'b1;
         step();
      end
      sv_v = 1'b0;
      check("mid_vec_pre", bus1.vec_cnt, 2);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      rst_n = 1'b1;
      set_vec(2'b11, 6'b000000);
      sv_v = 1'b1;
      step();
      step();
      sv_v = 1'b0;
      step();
      check("midrst_vec",  bus1.vec_cnt, 0);
      check("midrst_busy", bus1.busy, 0);
      check("midrst_done", bus1.done, 0);

      // Recovery session after the mid-session reset.
      begin_session();
      run_vectors(8'b11_10_01_00, 24'h000000, good_e, 1'b1);

      check("sb_pending", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
